// File: rtl/ripemd160_left_round_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ripemd160_left_round_ctrl_pkg
// Shared definitions for the RIPEMD-160 left-line round controller:
//   - fsm_e       : controller state encoding (IDLE, BUSY, DONE)
//   - K_LEFT      : left-line round constants, one per 16-step round
//   - R_LEFT      : message-word index for each of the 80 steps
//   - S_LEFT      : rotate amount for each of the 80 steps
//   - packing     : bit positions of A..E inside the 160-bit state word
// ----------------------------------------------------------------------------
package ripemd160_left_round_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam int WORD_W   = 32;
  localparam int STATE_W  = 160;
  localparam int BLOCK_W  = 512;
  localparam int STEP_W   = 7;
  localparam int TAB_LEN  = 80;

  // State packing: {A,B,C,D,E}, A in the most significant word.
  localparam int A_LSB = 128;
  localparam int B_LSB = 96;
  localparam int C_LSB = 64;
  localparam int D_LSB = 32;
  localparam int E_LSB = 0;

  localparam logic [31:0] K_LEFT [5] = '{
    32'h0000_0000, 32'h5A82_7999, 32'h6ED9_EBA1, 32'h8F1B_BCDC, 32'hA953_FD4E
  };

  localparam logic [3:0] R_LEFT [TAB_LEN] = '{
    4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,
    4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15,
    4'd7,  4'd4,  4'd13, 4'd1,  4'd10, 4'd6,  4'd15, 4'd3,
    4'd12, 4'd0,  4'd9,  4'd5,  4'd2,  4'd14, 4'd11, 4'd8,
    4'd3,  4'd10, 4'd14, 4'd4,  4'd9,  4'd15, 4'd8,  4'd1,
    4'd2,  4'd7,  4'd0,  4'd6,  4'd13, 4'd11, 4'd5,  4'd12,
    4'd1,  4'd9,  4'd11, 4'd10, 4'd0,  4'd8,  4'd12, 4'd4,
    4'd13, 4'd3,  4'd7,  4'd15, 4'd14, 4'd5,  4'd6,  4'd2,
    4'd4,  4'd0,  4'd5,  4'd9,  4'd7,  4'd12, 4'd2,  4'd10,
    4'd14, 4'd1,  4'd3,  4'd8,  4'd11, 4'd6,  4'd15, 4'd13
  };

  localparam logic [3:0] S_LEFT [TAB_LEN] = '{
    4'd11, 4'd14, 4'd15, 4'd12, 4'd5,  4'd8,  4'd7,  4'd9,
    4'd11, 4'd13, 4'd14, 4'd15, 4'd6,  4'd7,  4'd9,  4'd8,
    4'd7,  4'd6,  4'd8,  4'd13, 4'd11, 4'd9,  4'd7,  4'd15,
    4'd7,  4'd12, 4'd15, 4'd9,  4'd11, 4'd7,  4'd13, 4'd12,
    4'd11, 4'd13, 4'd6,  4'd7,  4'd14, 4'd9,  4'd13, 4'd15,
    4'd14, 4'd8,  4'd13, 4'd6,  4'd5,  4'd12, 4'd7,  4'd5,
    4'd11, 4'd12, 4'd14, 4'd15, 4'd14, 4'd15, 4'd9,  4'd8,
    4'd9,  4'd14, 4'd5,  4'd6,  4'd8,  4'd6,  4'd5,  4'd12,
    4'd9,  4'd15, 4'd5,  4'd11, 4'd6,  4'd8,  4'd13, 4'd12,
    4'd5,  4'd12, 4'd13, 4'd14, 4'd11, 4'd8,  4'd5,  4'd6
  };

endpackage

// File: rtl/ripemd160_left_round_ctrl_if.sv
// ----------------------------------------------------------------------------
// ripemd160_left_round_ctrl_if
// Block-in / state-out handshake bundle for the left-line round controller.
//   in_valid/in_ready   : offer of one 512-bit block plus 160-bit chaining value
//   in_block, in_cv     : block (word i = in_block[32*i +: 32]) and {A,B,C,D,E}
//   out_valid/out_ready : final left-line state handshake
//   out_state           : final {A,B,C,D,E}
// master = producer/consumer side, slave = controller side.
// ----------------------------------------------------------------------------
interface ripemd160_left_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_block;
  logic [159:0] in_cv;
  logic         out_valid;
  logic         out_ready;
  logic [159:0] out_state;

  modport master (
    output in_valid, in_block, in_cv, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_block, in_cv, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/ripemd160_left_round_ctrl_sched.sv
// ----------------------------------------------------------------------------
// ripemd160_left_sched
// Combinational per-step schedule lookup for the RIPEMD-160 left line.
//   step   in  7  step index 0..79
//   active in  1  controller is stepping; all outputs are zero otherwise
//   m_idx  out 4  message word index for this step
//   s      out 8  rotate amount (5..15)
//   k      out 32 round constant
//   t      out 3  boolean function select 0..4
// ----------------------------------------------------------------------------
module ripemd160_left_sched
  import ripemd160_left_round_ctrl_pkg::*;
(
  input  logic [STEP_W-1:0] step,
  input  logic              active,
  output logic [3:0]        m_idx,
  output logic [7:0]        s,
  output logic [31:0]       k,
  output logic [2:0]        t
);

  logic [2:0] round;

  // 16 steps per round, so the round number is simply the upper step bits.
  assign round = step[6:4];

  always_comb begin
    m_idx = '0;
    s     = '0;
    k     = '0;
    t     = '0;
    if (active && (step < 7'(TAB_LEN))) begin
      m_idx = R_LEFT[step];
      s     = {4'b0000, S_LEFT[step]};
      k     = K_LEFT[round];
      t     = round;
    end
  end

endmodule

// File: rtl/ripemd160_left_round_ctrl.sv
// ----------------------------------------------------------------------------
// ripemd160_left_round_ctrl
// Sequences the 80-step RIPEMD-160 left line over an external single-step
// datapath (one step per clock). Holds the message block and working state,
// drives the per-step controls and returns the final left-line state.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus (slave)   in_valid/in_ready/in_block/in_cv, out_valid/out_ready/out_state
//   abort         (only with RMD_LEFT_CTRL_ABORT_EN) drop the current block
//   dp_data_in    current state to the datapath
//   dp_m/dp_s     message word / rotate amount for the current step
//   dp_k/dp_t     round constant / function select for the current step
//   dp_left_out   datapath next-state result (combinational from dp_*)
//
// Configuration macro: RMD_LEFT_CTRL_ABORT_EN adds the abort input. Without
// it a block runs to completion or until rst.
// ----------------------------------------------------------------------------
module ripemd160_left_round_ctrl
  import ripemd160_left_round_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = 80
) (
  input  logic                clk,
  input  logic                rst,
  ripemd160_left_round_ctrl_if.slave bus,
`ifdef RMD_LEFT_CTRL_ABORT_EN
  input  logic                abort,
`endif
  output logic [STATE_W-1:0]  dp_data_in,
  output logic [WORD_W-1:0]   dp_m,
  output logic [7:0]          dp_s,
  output logic [WORD_W-1:0]   dp_k,
  output logic [2:0]          dp_t,
  input  logic [STATE_W-1:0]  dp_left_out
);

  fsm_e                fsm;
  fsm_e                fsm_nxt;
  logic [STEP_W-1:0]   step;
  logic [STATE_W-1:0]  state_reg;
  logic [BLOCK_W-1:0]  blk_reg;
  logic                busy;
  logic                accept;
  logic                last_step;
  logic                abort_req;
  logic [3:0]          m_idx;
  logic [7:0]          sched_s;
  logic [WORD_W-1:0]   sched_k;
  logic [2:0]          sched_t;

`ifdef RMD_LEFT_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign accept    = (fsm == IDLE) && bus.in_valid;
  assign last_step = (step == STEP_W'(NUM_STEPS - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  // FSM next-state logic
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE: if (bus.in_valid) fsm_nxt = BUSY;
      BUSY: begin
        if (abort_req)      fsm_nxt = IDLE;
        else if (last_step) fsm_nxt = DONE;
      end
      // A coincident abort and out_ready still counts as a completed
      // handshake; both lead back to IDLE.
      DONE: if (bus.out_ready || abort_req) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (fsm)
      IDLE:    bus.in_ready  = 1'b1;
      BUSY:    busy          = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Step counter and working state: loaded at accept, advanced every BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      step      <= '0;
      state_reg <= '0;
    end else if (accept) begin
      step      <= '0;
      state_reg <= bus.in_cv;
    end else if (busy) begin
      state_reg <= dp_left_out;
      step      <= last_step ? '0 : step + 1'b1;
    end
  end

  // Message block is only sampled at the accept edge.
  always_ff @(posedge clk) begin
    if (accept) blk_reg <= bus.in_block;
  end

  ripemd160_left_sched u_sched (
    .step   (step),
    .active (busy),
    .m_idx  (m_idx),
    .s      (sched_s),
    .k      (sched_k),
    .t      (sched_t)
  );

  assign dp_data_in    = state_reg;
  assign dp_m          = busy ? blk_reg[{m_idx, 5'b00000} +: WORD_W] : '0;
  assign dp_s          = sched_s;
  assign dp_k          = sched_k;
  assign dp_t          = sched_t;
  assign bus.out_state = state_reg;

endmodule

// File: tb/tb_ripemd160_left_round_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ripemd160_left_round_ctrl
// Self-checking bench: attaches a behavioural left-line step datapath to the
// controller, checks schedule outputs against a hand-written vector table and
// an independent schedule model, and checks final states against a golden
// 80-step reference.
// ----------------------------------------------------------------------------
module tb_ripemd160_left_round_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [159:0] dp_data_in;
  logic [31:0]  dp_m;
  logic [7:0]   dp_s;
  logic [31:0]  dp_k;
  logic [2:0]   dp_t;
  logic [159:0] dp_left_out;
`ifdef RMD_LEFT_CTRL_ABORT_EN
  logic         abort;
`endif

  always #5 clk = ~clk;

  ripemd160_left_round_ctrl_if bus ();

  ripemd160_left_round_ctrl #(.NUM_STEPS(80)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
`ifdef RMD_LEFT_CTRL_ABORT_EN
    .abort       (abort),
`endif
    .dp_data_in  (dp_data_in),
    .dp_m        (dp_m),
    .dp_s        (dp_s),
    .dp_k        (dp_k),
    .dp_t        (dp_t),
    .dp_left_out (dp_left_out)
  );

  // Left-line word index: rounds 1..4 apply the permutation RHO repeatedly.
  localparam int RHO [16] = '{7, 4, 13, 1, 10, 6, 15, 3, 12, 0, 9, 5, 2, 14, 11, 8};
  localparam int S_TAB [80] = '{
    11, 14, 15, 12, 5, 8, 7, 9, 11, 13, 14, 15, 6, 7, 9, 8,
    7, 6, 8, 13, 11, 9, 7, 15, 7, 12, 15, 9, 11, 7, 13, 12,
    11, 13, 6, 7, 14, 9, 13, 15, 14, 8, 13, 6, 5, 12, 7, 5,
    11, 12, 14, 15, 14, 15, 9, 8, 9, 14, 5, 6, 8, 6, 5, 12,
    9, 15, 5, 11, 6, 8, 13, 12, 5, 12, 13, 14, 11, 8, 5, 6
  };

  function automatic int model_r(input int j);
    int idx;
    idx = j % 16;
    for (int q = 0; q < j / 16; q++) idx = RHO[idx];
    return idx;
  endfunction

  function automatic logic [31:0] model_k(input int round);
    case (round)
      1:       return 32'h5A827999;
      2:       return 32'h6ED9EBA1;
      3:       return 32'h8F1BBCDC;
      4:       return 32'hA953FD4E;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] fsel(input int t, input logic [31:0] b, c, d);
    case (t)
      0:       return b ^ c ^ d;
      1:       return (b & c) | (~b & d);
      2:       return (b | ~c) ^ d;
      3:       return (b & d) | (c & ~d);
      4:       return b ^ (c | ~d);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [159:0] step_fn(input logic [159:0] st, input logic [31:0] m,
                                           input int s, input logic [31:0] k, input int t);
    logic [31:0] a, b, c, d, e, tt;
    {a, b, c, d, e} = st;
    tt = rol(a + fsel(t, b, c, d) + m + k, s) + e;
    return {e, tt, b, rol(c, 10), d};
  endfunction

  function automatic logic [159:0] golden(input logic [511:0] blk, input logic [159:0] cv);
    logic [159:0] st;
    st = cv;
    for (int j = 0; j < 80; j++)
      st = step_fn(st, blk[32*model_r(j) +: 32], S_TAB[j], model_k(j / 16), j / 16);
    return st;
  endfunction

  // Behavioural single-step datapath.
  always_comb dp_left_out = step_fn(dp_data_in, dp_m, int'(dp_s), dp_k, int'(dp_t));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          step;
    logic [31:0] m;
    logic [7:0]  s;
    logic [31:0] k;
    logic [2:0]  t;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] cap_m [80];
  logic [7:0]  cap_s [80];
  logic [31:0] cap_k [80];
  logic [2:0]  cap_t [80];
  int          busy_ready_hi;

  task automatic scramble_inputs();
    for (int w = 0; w < 16; w++) bus.in_block[32*w +: 32] = $urandom();
    for (int w = 0; w < 5; w++)  bus.in_cv[32*w +: 32]    = $urandom();
  endtask

  task automatic accept(input logic [511:0] blk, input logic [159:0] cv);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_block = blk;
    bus.in_cv    = cv;
    check("accept_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
  endtask

  // Accept a block, capture per-step controls, return edges until out_valid
  // (the accept edge counts as edge 1). Leaves the bench at the negedge where
  // out_valid was first seen.
  task automatic run_block(input logic [511:0] blk, input logic [159:0] cv, output int lat);
    accept(blk, cv);
    bus.in_valid  = 1'b1;
    busy_ready_hi = 0;
    lat = 1;
    while (lat < 200) begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (lat <= 80) begin
        cap_m[lat-1] = dp_m;
        cap_s[lat-1] = dp_s;
        cap_k[lat-1] = dp_k;
        cap_t[lat-1] = dp_t;
        if (bus.in_ready) busy_ready_hi++;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    check("busy_in_ready_low", busy_ready_hi, 0);
  endtask

  task automatic finish_handshake();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("post_handshake_out_valid", bus.out_valid, 0);
    check("post_handshake_in_ready", bus.in_ready, 1);
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    int pulses;
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    check(name, pulses, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] blk_a, blk_e, blk_r;
    logic [159:0] cv_e, cv_r, held;
    logic [31:0]  w;
    int           lat;

    vecs[0]  = '{0,  32'h1000_0000, 8'd11, 32'h0,          3'd0};
    vecs[1]  = '{1,  32'h1000_0001, 8'd14, 32'h0,          3'd0};
    vecs[2]  = '{15, 32'h1000_000F, 8'd8,  32'h0,          3'd0};
    vecs[3]  = '{16, 32'h1000_0007, 8'd7,  32'h5A827999,   3'd1};
    vecs[4]  = '{17, 32'h1000_0004, 8'd6,  32'h5A827999,   3'd1};
    vecs[5]  = '{31, 32'h1000_0008, 8'd12, 32'h5A827999,   3'd1};
    vecs[6]  = '{32, 32'h1000_0003, 8'd11, 32'h6ED9EBA1,   3'd2};
    vecs[7]  = '{47, 32'h1000_000C, 8'd5,  32'h6ED9EBA1,   3'd2};
    vecs[8]  = '{48, 32'h1000_0001, 8'd11, 32'h8F1BBCDC,   3'd3};
    vecs[9]  = '{63, 32'h1000_0002, 8'd12, 32'h8F1BBCDC,   3'd3};
    vecs[10] = '{64, 32'h1000_0004, 8'd9,  32'hA953FD4E,   3'd4};
    vecs[11] = '{79, 32'h1000_000D, 8'd6,  32'hA953FD4E,   3'd4};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_block  = '0;
    bus.in_cv     = '0;
    bus.out_ready = 1'b0;
`ifdef RMD_LEFT_CTRL_ABORT_EN
    abort         = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_dp_data_in", dp_data_in, 0);
    check("reset_out_state", bus.out_state, 0);
    check("reset_dp_ctrl", {dp_m, dp_s, dp_k, dp_t}, 0);

    // Counting-word block, zero chaining value
    for (int i = 0; i < 16; i++) begin
      w = 32'h1000_0000 + i;
      blk_a[32*i +: 32] = w;
    end
    run_block(blk_a, 160'h0, lat);
    check("latency_a", lat, 81);
    check("out_state_a", bus.out_state, golden(blk_a, 160'h0));
    for (int v = 0; v < 12; v++) begin
      check($sformatf("vec_m_step%0d", vecs[v].step), cap_m[vecs[v].step], vecs[v].m);
      check($sformatf("vec_s_step%0d", vecs[v].step), cap_s[vecs[v].step], vecs[v].s);
      check($sformatf("vec_k_step%0d", vecs[v].step), cap_k[vecs[v].step], vecs[v].k);
      check($sformatf("vec_t_step%0d", vecs[v].step), cap_t[vecs[v].step], vecs[v].t);
    end
    for (int j = 0; j < 80; j++)
      check($sformatf("sched_step%0d", j), {cap_m[j], cap_s[j], cap_k[j], cap_t[j]},
            {blk_a[32*model_r(j) +: 32], 8'(S_TAB[j]), model_k(j / 16), 3'(j / 16)});

    // DONE held with out_ready low while a new block is offered
    held = bus.out_state;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_in_ready", bus.in_ready, 0);
      check("hold_out_state", bus.out_state, held);
    end
    check("done_dp_ctrl_zero", {dp_m, dp_s, dp_k, dp_t}, 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("hold_release_in_ready", bus.in_ready, 1);
    check("hold_release_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;

    // Empty-message padded block with the standard initial chaining value
    blk_e = '0;
    blk_e[31:0] = 32'h0000_0080;
    cv_e = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
    run_block(blk_e, cv_e, lat);
    check("latency_empty", lat, 81);
    check("out_state_empty", bus.out_state, golden(blk_e, cv_e));
    finish_handshake();

    // Reset in the middle of a block
    accept(blk_a, cv_e);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("rst_pre_step40_m", dp_m, blk_a[32*model_r(40) +: 32]);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", bus.in_ready, 1);
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_dp_data_in", dp_data_in, 0);
    watch_no_valid("rst_mid_no_out_valid", 100);
    for (int i = 0; i < 16; i++) blk_r[32*i +: 32] = $urandom();
    for (int i = 0; i < 5; i++)  cv_r[32*i +: 32]  = $urandom();
    run_block(blk_r, cv_r, lat);
    check("latency_after_rst", lat, 81);
    check("out_state_after_rst", bus.out_state, golden(blk_r, cv_r));
    finish_handshake();

`ifdef RMD_LEFT_CTRL_ABORT_EN
    // Abort at step 20
    accept(blk_r, cv_e);
    repeat (20) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy_in_ready", bus.in_ready, 1);
    check("abort_busy_out_valid", bus.out_valid, 0);
    watch_no_valid("abort_busy_no_out_valid", 100);

    // Abort coinciding with out_ready in DONE
    run_block(blk_e, cv_r, lat);
    check("latency_abort_done", lat, 81);
    check("abort_done_out_valid", bus.out_valid, 1);
    check("abort_done_out_state", bus.out_state, golden(blk_e, cv_r));
    abort         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    abort         = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("abort_done_in_ready", bus.in_ready, 1);
    watch_no_valid("abort_done_single_handshake", 20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
